muldiv_wb_queue: RTL and testbench
==================================

MULDIV_WB_QUEUE -- requirements
Module: muldiv_wb_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, >=2): writeback queue entries.
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 muldiv_start  in  1  issue strobe, same cycle as muldiv_unit start.
REQ-006 muldiv_hart_id  in  `HART_ID_W  issuing hart.
REQ-007 muldiv_done  in  1  single-cycle completion pulse from muldiv_unit; no backpressure.
REQ-008 muldiv_result  in  `XLEN  completion data.
REQ-009 muldiv_done_hart_id  in  `HART_ID_W  completing hart.
REQ-010 muldiv_done_rd  in  `REG_ADDR_W  destination register.
REQ-011 wb_pipe_valid  in  1  main pipeline owns the regfile write port this cycle.
REQ-012 wb_valid  out  1  queue writes the regfile this cycle.
REQ-013 wb_hart_id, wb_rd, wb_data  out  `HART_ID_W / `REG_ADDR_W / `XLEN  head entry fields.
REQ-014 hart_pending  out  2**`HART_ID_W  per-hart outstanding-muldiv mask, for the issue stall.
REQ-015 q_full  out  1  queue full; issue logic holds muldiv_start while asserted.
REQ-016 ovf_err, proto_err  out  1 each  sticky error flags.

Function
REQ-017 The block SHALL enqueue {hart_id, rd, result} on each rising edge where muldiv_done=1 and muldiv_done_rd!=0.
REQ-018 A done with rd=0 SHALL not be enqueued and SHALL clear that hart's pending bit at the same edge.
REQ-019 The block SHALL provide no bypass: minimum latency is one cycle from muldiv_done sampled to wb_valid=1.
REQ-020 wb_valid SHALL be combinational: (queue not empty) AND NOT wb_pipe_valid. wb_hart_id, wb_rd and wb_data SHALL always show the head entry.
REQ-021 The head SHALL be popped at each edge where wb_valid=1; entries drain strictly FIFO, one per cycle at most.
REQ-022 Enqueue when full SHALL succeed only if a pop occurs at the same edge. Otherwise the entry is dropped, the queue is unchanged, and ovf_err sets.
REQ-023 Simultaneous enqueue and pop at any occupancy SHALL leave the count unchanged.
REQ-024 Pointers SHALL wrap modulo DEPTH. The count SHALL be held in a $clog2(DEPTH)+1-bit register.
REQ-025 q_full SHALL be 1 exactly when count==DEPTH.
REQ-026 hart_pending[h] SHALL set at the edge where muldiv_start=1 and muldiv_hart_id==h.
REQ-027 hart_pending[h] SHALL clear at the edge where an entry with hart h is popped, or per REQ-018.
REQ-028 If set and clear hit the same hart at the same edge, set SHALL win.
REQ-029 muldiv_start for a hart whose pending bit is already 1 SHALL set proto_err; the pending bit stays 1.
REQ-030 A pop or rd=0 done for a hart whose pending bit is 0 SHALL set proto_err.
REQ-031 ovf_err and proto_err SHALL clear only on reset.

Reset
REQ-032 On rst_n=0 the block SHALL immediately clear count, pointers, hart_pending, ovf_err and proto_err. wb_valid and q_full are therefore 0.
REQ-033 Queue data storage SHALL need no reset. wb_* data fields are don't-care while wb_valid=0.
REQ-034 Reset mid-operation SHALL discard all queued entries with no writeback. The first edge after deassertion SHALL behave as from empty.

Structure
REQ-035 The default depth SHALL be defined in defines.vh as `MULDIV_WBQ_DEPTH, alongside `XLEN, `HART_ID_W and `REG_ADDR_W.
REQ-036 Storage and pointers SHALL be one sub-module, muldiv_wbq_fifo: a synchronous FIFO with push/pop/full/empty.
REQ-037 The pending scoreboard and error logic SHALL sit in muldiv_wb_queue.

Verification
REQ-038 MUL 0x1234 x 0x5678 from hart 1 to rd 5, wb_pipe_valid=0:
- wb_valid=1 one cycle after done, with data 0x06260060, rd 5, hart 1;
- hart_pending[1] is 1 from the start edge and clears on the pop.
REQ-039 Done for hart 0 / rd 3 while wb_pipe_valid=1 for 3 cycles: wb_valid stays 0 for 3 cycles, then pulses 1 cycle; the entry is not lost.
REQ-040 DEPTH+1 dones with wb_pipe_valid held 1:
- q_full=1 after DEPTH;
- the last done sets ovf_err;
- on release, DEPTH entries drain in order, one per cycle.
REQ-041 Done rd=0 for pending hart 2: no wb_valid; hart_pending[2]=0 next cycle; proto_err stays 0.
REQ-042 Two muldiv_start for hart 0 with no completion between: proto_err=1.
REQ-043 Same-edge start hart 1 and pop hart 1: hart_pending[1] stays 1.
REQ-044 rst_n pulsed low with 2 entries queued: wb_valid=0 and hart_pending=0 immediately; no writeback after release.

Source files
------------

// File: rtl/muldiv_wb_queue_pkg.sv
// muldiv_wb_queue_pkg: shared widths, default depth and writeback entry type
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef MULDIV_WBQ_DEPTH
`define MULDIV_WBQ_DEPTH 4
`endif

package muldiv_wb_queue_pkg;
    localparam int XLEN       = `XLEN;
    localparam int HART_ID_W  = `HART_ID_W;
    localparam int REG_ADDR_W = `REG_ADDR_W;
    localparam int WBQ_DEPTH  = `MULDIV_WBQ_DEPTH;
    localparam int NUM_HARTS  = 2 ** HART_ID_W;

    typedef struct packed {
        logic [HART_ID_W-1:0]  hart_id;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // One-hot hart mask, all zero when en is low
    function automatic logic [NUM_HARTS-1:0] hart_mask(input logic [HART_ID_W-1:0] h, input logic en);
        return {{(NUM_HARTS-1){1'b0}}, en} << h;
    endfunction
endpackage

// File: rtl/muldiv_wbq_fifo.sv
// muldiv_wbq_fifo: synchronous FIFO holding completed muldiv results until the regfile port is free
module muldiv_wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two; a full queue accepts a push only alongside a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is unreset; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/muldiv_wb_queue.sv
// muldiv_wb_queue: queues muldiv completions for regfile writeback and tracks per-hart outstanding ops
module muldiv_wb_queue
    import muldiv_wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  muldiv_start,
    input  logic [HART_ID_W-1:0]  muldiv_hart_id,
    input  logic                  muldiv_done,
    input  logic [XLEN-1:0]       muldiv_result,
    input  logic [HART_ID_W-1:0]  muldiv_done_hart_id,
    input  logic [REG_ADDR_W-1:0] muldiv_done_rd,
    input  logic                  wb_pipe_valid,
    output logic                  wb_valid,
    output logic [HART_ID_W-1:0]  wb_hart_id,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [NUM_HARTS-1:0]  hart_pending,
    output logic                  q_full,
    output logic                  ovf_err,
    output logic                  proto_err
);
    wb_entry_t            enq_entry;
    wb_entry_t            head;
    logic                 empty;
    logic                 enq;
    logic                 rd_zero;
    logic                 pop;
    logic [NUM_HARTS-1:0] pending_nxt;
    logic                 proto_hit;
    logic                 ovf_hit;

    assign enq       = muldiv_done && (muldiv_done_rd != '0);
    assign rd_zero   = muldiv_done && (muldiv_done_rd == '0);
    assign wb_valid  = !empty && !wb_pipe_valid;
    assign pop       = wb_valid;
    assign enq_entry = '{hart_id: muldiv_done_hart_id, rd: muldiv_done_rd, data: muldiv_result};
    assign wb_hart_id = head.hart_id;
    assign wb_rd      = head.rd;
    assign wb_data    = head.data;

    muldiv_wbq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enq),
        .pop   (pop),
        .din   (enq_entry),
        .dout  (head),
        .full  (q_full),
        .empty (empty)
    );

    // Pending scoreboard update (set beats clear) and protocol/overflow error detection against the current mask
    always_comb begin
        pending_nxt = (hart_pending & ~(hart_mask(head.hart_id, pop) | hart_mask(muldiv_done_hart_id, rd_zero)))
                    | hart_mask(muldiv_hart_id, muldiv_start);
        proto_hit   = (muldiv_start && hart_pending[muldiv_hart_id])
                    || (pop && !hart_pending[head.hart_id])
                    || (rd_zero && !hart_pending[muldiv_done_hart_id]);
        ovf_hit     = enq && q_full && !pop;
    end

    // Scoreboard and sticky error flags; errors clear only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hart_pending <= '0;
            ovf_err      <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            hart_pending <= pending_nxt;
            ovf_err      <= ovf_err || ovf_hit;
            proto_err    <= proto_err || proto_hit;
        end
    end
endmodule

// File: tb/tb_muldiv_wb_queue.sv
// tb_muldiv_wb_queue: directed and random stimulus against a queue-based reference model with a writeback scoreboard
module tb_muldiv_wb_queue;
    import muldiv_wb_queue_pkg::*;

    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  muldiv_start = 1'b0;
    logic [HART_ID_W-1:0]  muldiv_hart_id = '0;
    logic                  muldiv_done = 1'b0;
    logic [XLEN-1:0]       muldiv_result = '0;
    logic [HART_ID_W-1:0]  muldiv_done_hart_id = '0;
    logic [REG_ADDR_W-1:0] muldiv_done_rd = '0;
    logic                  wb_pipe_valid = 1'b0;
    logic                  wb_valid;
    logic [HART_ID_W-1:0]  wb_hart_id;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic [NUM_HARTS-1:0]  hart_pending;
    logic                  q_full;
    logic                  ovf_err;
    logic                  proto_err;

    int vectors = 0;
    int miscompares = 0;

    wb_entry_t            mq[$];
    wb_entry_t            exp_q[$];
    logic [NUM_HARTS-1:0] mpend = '0;
    logic [NUM_HARTS-1:0] np;
    logic                 movf = 1'b0;
    logic                 mproto = 1'b0;
    logic                 m_pop;
    logic                 m_full;
    wb_entry_t            m_head;

    muldiv_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .muldiv_start        (muldiv_start),
        .muldiv_hart_id      (muldiv_hart_id),
        .muldiv_done         (muldiv_done),
        .muldiv_result       (muldiv_result),
        .muldiv_done_hart_id (muldiv_done_hart_id),
        .muldiv_done_rd      (muldiv_done_rd),
        .wb_pipe_valid       (wb_pipe_valid),
        .wb_valid            (wb_valid),
        .wb_hart_id          (wb_hart_id),
        .wb_rd               (wb_rd),
        .wb_data             (wb_data),
        .hart_pending        (hart_pending),
        .q_full              (q_full),
        .ovf_err             (ovf_err),
        .proto_err           (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        muldiv_start = 1'b0;
        muldiv_done  = 1'b0;
        muldiv_done_rd = '0;
    endtask

    task automatic do_start(input int h);
        muldiv_start   = 1'b1;
        muldiv_hart_id = HART_ID_W'(h);
    endtask

    task automatic do_done(input int h, input int rd, input logic [XLEN-1:0] d);
        muldiv_done         = 1'b1;
        muldiv_done_hart_id = HART_ID_W'(h);
        muldiv_done_rd      = REG_ADDR_W'(rd);
        muldiv_result       = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_pipe_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("reset_pending", 64'(hart_pending), 64'd0);
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model: a plain FIFO of entries and a pending bit per hart, evaluated at every edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            mpend  = '0;
            movf   = 1'b0;
            mproto = 1'b0;
        end else begin
            m_pop  = mq.size() != 0 && !wb_pipe_valid;
            m_full = mq.size() == DEPTH;
            np = mpend;
            if (muldiv_start && mpend[muldiv_hart_id]) mproto = 1'b1;
            if (m_pop) begin
                m_head = mq.pop_front();
                if (!mpend[m_head.hart_id]) mproto = 1'b1;
                np[m_head.hart_id] = 1'b0;
            end
            if (muldiv_done && muldiv_done_rd == 0) begin
                if (!mpend[muldiv_done_hart_id]) mproto = 1'b1;
                np[muldiv_done_hart_id] = 1'b0;
            end
            if (muldiv_start) np[muldiv_hart_id] = 1'b1;
            mpend = np;
            if (muldiv_done && muldiv_done_rd != 0) begin
                if (!m_full || m_pop) begin
                    mq.push_back('{hart_id: muldiv_done_hart_id, rd: muldiv_done_rd, data: muldiv_result});
                    exp_q.push_back('{hart_id: muldiv_done_hart_id, rd: muldiv_done_rd, data: muldiv_result});
                end else begin
                    movf = 1'b1;
                end
            end
        end
    end

    // Monitor: every cycle compare status outputs, and pop the scoreboard whenever a writeback is presented
    initial forever begin
        wb_entry_t e;
        @(negedge clk);
        chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0 && !wb_pipe_valid));
        chk("hart_pending", 64'(hart_pending), 64'(mpend));
        chk("q_full", 64'(q_full), 64'(mq.size() == DEPTH));
        chk("ovf_err", 64'(ovf_err), 64'(movf));
        chk("proto_err", 64'(proto_err), 64'(mproto));
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_wb", 64'(wb_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_hart", 64'(wb_hart_id), 64'(e.hart_id));
                chk("sb_rd", 64'(wb_rd), 64'(e.rd));
                chk("sb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("por_wb_valid", 64'(wb_valid), 64'd0);
        chk("por_q_full", 64'(q_full), 64'd0);
        chk("por_errs", 64'({ovf_err, proto_err}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single multiply from hart 1 to rd 5
        do_start(1);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("mul_pending_set", 64'(hart_pending[1]), 64'd1);
        tick();
        do_done(1, 5, 32'h1234 * 32'h5678);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("mul_wb_valid", 64'(wb_valid), 64'd1);
        chk("mul_wb_data", 64'(wb_data), 64'h0626_0060);
        chk("mul_wb_rd", 64'(wb_rd), 64'd5);
        chk("mul_wb_hart", 64'(wb_hart_id), 64'd1);
        tick();
        @(negedge clk);
        chk("mul_pending_clr", 64'(hart_pending[1]), 64'd0);
        chk("mul_wb_after_pop", 64'(wb_valid), 64'd0);

        // Writeback deferred by the main pipeline for three cycles
        tick();
        do_start(0);
        tick();
        idle_inputs();
        do_done(0, 3, 32'hcafe_0003);
        wb_pipe_valid = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("blocked_wb_valid", 64'(wb_valid), 64'd0);
            tick();
        end
        wb_pipe_valid = 1'b0;
        @(negedge clk);
        chk("released_wb_valid", 64'(wb_valid), 64'd1);
        chk("released_wb_rd", 64'(wb_rd), 64'd3);
        tick();
        @(negedge clk);
        chk("released_single_pulse", 64'(wb_valid), 64'd0);

        // Fill past capacity while the pipeline owns the port, then drain in order
        tick();
        do_reset();
        wb_pipe_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            do_done(i % NUM_HARTS, i + 1, $urandom);
            @(negedge clk);
            chk("fill_q_full", 64'(q_full), 64'(i == DEPTH));
            chk("fill_ovf_clear", 64'(ovf_err), 64'd0);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk("ovf_q_full", 64'(q_full), 64'd1);
        chk("ovf_set", 64'(ovf_err), 64'd1);
        tick();
        wb_pipe_valid = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk);
            chk("drain_valid", 64'(wb_valid), 64'd1);
            chk("drain_rd", 64'(wb_rd), 64'(j + 1));
            tick();
        end
        @(negedge clk);
        chk("drain_done", 64'(wb_valid), 64'd0);

        // Done with rd 0 retires a pending op without writeback
        tick();
        do_reset();
        do_start(2);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("rd0_pending_set", 64'(hart_pending[2]), 64'd1);
        tick();
        do_done(2, 0, 32'h1111_2222);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("rd0_no_wb", 64'(wb_valid), 64'd0);
        chk("rd0_pending_clr", 64'(hart_pending[2]), 64'd0);
        chk("rd0_no_proto", 64'(proto_err), 64'd0);

        // Double issue from hart 0
        tick();
        do_start(0);
        tick();
        idle_inputs();
        tick();
        do_start(0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("double_start_proto", 64'(proto_err), 64'd1);
        chk("double_start_pending", 64'(hart_pending[0]), 64'd1);

        // New issue and retirement for hart 1 on the same edge
        tick();
        do_reset();
        do_start(1);
        tick();
        idle_inputs();
        do_done(1, 7, 32'h7777_7777);
        tick();
        idle_inputs();
        do_start(1);
        @(negedge clk);
        chk("same_edge_pop_ready", 64'(wb_valid), 64'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("same_edge_set_wins", 64'(hart_pending[1]), 64'd1);

        // Reset with two queued entries discards them
        tick();
        do_reset();
        wb_pipe_valid = 1'b1;
        do_start(0);
        tick();
        do_start(1);
        tick();
        idle_inputs();
        do_done(0, 1, 32'h0000_00a1);
        tick();
        do_done(1, 2, 32'h0000_00a2);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("pre_reset_held", 64'(wb_valid), 64'd0);
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_wb", 64'(wb_valid), 64'd0);
            tick();
        end

        // Random traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            idle_inputs();
            if ($urandom_range(3) == 0) do_start($urandom_range(NUM_HARTS - 1));
            if ($urandom_range(2) == 0)
                do_done($urandom_range(NUM_HARTS - 1), ($urandom_range(7) == 0) ? 0 : $urandom_range(31, 1), $urandom);
            wb_pipe_valid = ($urandom_range(2) == 0);
            tick();
        end
        idle_inputs();
        wb_pipe_valid = 1'b0;
        repeat (DEPTH + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
